// File: rtl/z3_master_cycle.sv
// Zorro III bus-master engine: one single (non-burst) transfer per local request,
// terminated by target DTACK, bus error or a local DATA-phase timeout.
module z3_master_cycle #(
  parameter int unsigned TIMEOUT = 200
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic [31:0] req_addr_i,
  input  logic        req_read_i,
  input  logic [1:0]  req_siz_i,
  input  logic [31:0] req_wdata_i,
  input  logic        bus_grant_i,
  input  logic        dtack_n_i,
  input  logic        berr_n_i,
  input  logic [31:0] d_in_i,
  output logic [31:0] a_out_o,
  output logic        a_oe_o,
  output logic        fcs_n_out_o,
  output logic        doe_out_o,
  output logic        read_out_o,
  output logic [3:0]  ds_n_out_o,
  output logic [31:0] d_out_o,
  output logic        d_oe_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        tmo_o,
  output logic [31:0] rdata_o,
  output logic [2:0]  xfer_cnt_o
);

  // state     | meaning
  // S_IDLE    | waiting for REQ while granted
  // S_ADDR    | drive address and READ
  // S_STROBE  | assert FCS_n
  // S_DATA    | DS_n/DOE (and write data) driven, waiting for termination
  // S_END     | strobes released, status pulses
  // S_RECOVER | address released, waiting for DTACK/BERR to negate
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_STROBE, S_DATA, S_END, S_RECOVER
  } state_t;

  localparam logic [7:0] TMO_LIMIT = TIMEOUT[7:0];

  state_t      state_q;
  logic [1:0]  dtack_sync_q, berr_sync_q;
  logic        dtack_s, berr_s;
  logic [31:0] addr_q, wdata_q;
  logic        read_q, err_pend_q, tmo_pend_q;
  logic [3:0]  lane_en_q;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        data_first;
  logic [2:0]  nbytes;
  logic [3:0]  lane_en_d;
  logic [2:0]  xfer_cnt_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dtack_sync_q <= 2'b00;
      berr_sync_q  <= 2'b00;
    end else begin
      dtack_sync_q <= {dtack_sync_q[0], ~dtack_n_i};
      berr_sync_q  <= {berr_sync_q[0], ~berr_n_i};
    end
  end

  assign dtack_s = dtack_sync_q[1];
  assign berr_s  = berr_sync_q[1];

  // Lane k of the longword is driven on DS_n[3-k]; bytes beyond lane 3 are dropped.
  always_comb begin
    nbytes     = (req_siz_i == 2'b00) ? 3'd4 : {1'b0, req_siz_i};
    lane_en_d  = 4'b0000;
    xfer_cnt_d = 3'd0;
    for (int k = 0; k < 4; k++) begin
      lane_en_d[3-k] = (k >= int'(req_addr_i[1:0])) &&
                       (k < int'(req_addr_i[1:0]) + int'(nbytes));
      xfer_cnt_d = xfer_cnt_d + {2'b00, lane_en_d[3-k]};
    end
  end

  assign tmo_cnt_d  = tmo_cnt_q + 8'd1;
  // DS_n only reaches the bus on the first DATA edge, so no termination is taken there.
  assign data_first = (tmo_cnt_q == 8'd0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_q      <= 1'b1;
      lane_en_q   <= 4'b0000;
      err_pend_q  <= 1'b0;
      tmo_pend_q  <= 1'b0;
      tmo_cnt_q   <= 8'd0;
      a_out_o     <= '0;
      a_oe_o      <= 1'b0;
      fcs_n_out_o <= 1'b1;
      doe_out_o   <= 1'b0;
      read_out_o  <= 1'b1;
      ds_n_out_o  <= 4'b1111;
      d_out_o     <= '0;
      d_oe_o      <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      tmo_o       <= 1'b0;
      rdata_o     <= '0;
      xfer_cnt_o  <= 3'd0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      tmo_o  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_i && bus_grant_i) begin
            addr_q     <= req_addr_i;
            wdata_q    <= req_wdata_i;
            read_q     <= req_read_i;
            lane_en_q  <= lane_en_d;
            xfer_cnt_o <= xfer_cnt_d;
            err_pend_q <= 1'b0;
            tmo_pend_q <= 1'b0;
            tmo_cnt_q  <= 8'd0;
            busy_o     <= 1'b1;
            state_q    <= S_ADDR;
          end
        end
        S_ADDR: begin
          a_oe_o     <= 1'b1;
          a_out_o    <= addr_q;
          read_out_o <= read_q;
          state_q    <= S_STROBE;
        end
        S_STROBE: begin
          fcs_n_out_o <= 1'b0;
          state_q     <= S_DATA;
        end
        S_DATA: begin
          doe_out_o  <= 1'b1;
          ds_n_out_o <= ~lane_en_q;
          d_oe_o     <= ~read_q;
          d_out_o    <= wdata_q;
          tmo_cnt_q  <= tmo_cnt_d;
          if (!data_first && berr_s) begin
            err_pend_q <= 1'b1;
            state_q    <= S_END;
          end else if (!data_first && dtack_s) begin
            if (read_q) rdata_o <= d_in_i;
            state_q <= S_END;
          end else if (tmo_cnt_d == TMO_LIMIT) begin
            err_pend_q <= 1'b1;
            tmo_pend_q <= 1'b1;
            state_q    <= S_END;
          end
        end
        S_END: begin
          ds_n_out_o  <= 4'b1111;
          doe_out_o   <= 1'b0;
          d_oe_o      <= 1'b0;
          fcs_n_out_o <= 1'b1;
          done_o      <= 1'b1;
          err_o       <= err_pend_q;
          tmo_o       <= tmo_pend_q;
          state_q     <= S_RECOVER;
        end
        S_RECOVER: begin
          a_oe_o     <= 1'b0;
          read_out_o <= 1'b1;
          if (!dtack_s && !berr_s) begin
            busy_o  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z3_master_cycle.sv
// Bench for z3_master_cycle: a responding-target model plus a scoreboard of expected
// completion status checked on each DONE pulse.
module tb_z3_master_cycle;

  logic        clk = 1'b0;
  logic        reset, req, req_read, bus_grant, dtack_n, berr_n;
  logic [31:0] req_addr, req_wdata, d_in;
  logic [1:0]  req_siz;
  logic [31:0] a_out, d_out, rdata;
  logic        a_oe, fcs_n, doe, read_out, d_oe, busy, done, err, tmo;
  logic [3:0]  ds_n;
  logic [2:0]  xfer_cnt;

  always #20 clk = ~clk;

  z3_master_cycle #(.TIMEOUT(5)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .req_addr_i(req_addr),
    .req_read_i(req_read), .req_siz_i(req_siz), .req_wdata_i(req_wdata),
    .bus_grant_i(bus_grant), .dtack_n_i(dtack_n), .berr_n_i(berr_n), .d_in_i(d_in),
    .a_out_o(a_out), .a_oe_o(a_oe), .fcs_n_out_o(fcs_n), .doe_out_o(doe),
    .read_out_o(read_out), .ds_n_out_o(ds_n), .d_out_o(d_out), .d_oe_o(d_oe),
    .busy_o(busy), .done_o(done), .err_o(err), .tmo_o(tmo), .rdata_o(rdata),
    .xfer_cnt_o(xfer_cnt)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  ds;
    logic [2:0]  cnt;
    logic        err;
    logic        tmo;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rdata_model = '0;

  function automatic logic [3:0] model_ds(input logic [1:0] off, input logic [1:0] siz);
    int n, lane;
    logic [3:0] m;
    n = (siz == 2'b00) ? 4 : int'(siz);
    m = 4'b1111;
    for (int i = 0; i < n; i++) begin
      lane = int'(off) + i;
      if (lane <= 3) m[3-lane] = 1'b0;
    end
    return m;
  endfunction

  // mode: 0 = DTACK, 1 = BERR and DTACK together, 2 = no response
  task automatic xfer(input logic [31:0] addr, input logic rd, input logic [1:0] siz,
                      input logic [31:0] wd, input int mode, input int dly,
                      input logic [31:0] rdat, input int hold);
    exp_t e;
    logic [3:0] mds;
    int k, ds_cycles;
    bit got_done;
    mds     = model_ds(addr[1:0], siz);
    e.ds    = mds;
    e.cnt   = 3'(4 - $countones(mds));
    e.err   = (mode != 0);
    e.tmo   = (mode == 2);
    if (rd && mode == 0) rdata_model = rdat;
    e.rdata = rdata_model;
    sb.push_back(e);

    @(negedge clk);
    req = 1'b1; req_addr = addr; req_read = rd; req_siz = siz; req_wdata = wd;
    bus_grant = 1'b1; d_in = rdat;
    @(negedge clk);
    req = 1'b0; bus_grant = 1'b0;
    chk("busy_accept", busy, 1);
    chk("a_oe_edge0", a_oe, 0);
    @(negedge clk);
    chk("a_oe_edge1", a_oe, 1);
    chk("a_out", a_out, addr);
    chk("read_out", read_out, rd);
    chk("fcs_edge1", fcs_n, 1);
    @(negedge clk);
    chk("fcs_edge2", fcs_n, 0);
    chk("ds_edge2", ds_n, 4'hf);
    @(negedge clk);
    chk("ds_mask", ds_n, mds);
    chk("doe", doe, 1);
    chk("d_oe", d_oe, !rd);
    if (!rd) chk("d_out", d_out, wd);

    k = 0; ds_cycles = 1; got_done = 0;
    for (int c = 0; c < 64 && !got_done; c++) begin
      if (mode != 2 && k == dly) begin
        dtack_n = 1'b0;
        if (mode == 1) berr_n = 1'b0;
      end
      k++;
      @(negedge clk);
      if (done) got_done = 1;
      else if (ds_n != 4'hf) ds_cycles++;
    end
    if (!got_done) begin
      chk("done_seen", 0, 1);
      e = sb.pop_front();
    end else begin
      e = sb.pop_front();
      chk("err", err, e.err);
      chk("tmo", tmo, e.tmo);
      chk("xfer_cnt", xfer_cnt, e.cnt);
      chk("ds_end", ds_n, 4'hf);
      chk("rdata", rdata, e.rdata);
      if (mode == 2) chk("data_cycles", ds_cycles, 5);
    end

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (h == 0) chk("done_pulse", done, 0);
      chk("recover_hold", busy, 1);
    end
    dtack_n = 1'b1; berr_n = 1'b1;
    for (int c = 0; c < 16 && busy; c++) @(negedge clk);
    chk("busy_end", busy, 0);
    chk("a_oe_end", a_oe, 0);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; req_addr = '0; req_read = 1'b0; req_siz = 2'b00;
    req_wdata = '0; bus_grant = 1'b0; dtack_n = 1'b1; berr_n = 1'b1; d_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_fcs", fcs_n, 1);
    chk("rst_ds", ds_n, 4'hf);
    chk("rst_read", read_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_cnt", xfer_cnt, 0);
    reset = 1'b0;

    xfer(32'h4000_0010, 1'b1, 2'b00, 32'h0,          0, 1, 32'hDEAD_BEEF, 0);
    xfer(32'h0000_0002, 1'b0, 2'b01, 32'h0000_AB00,  0, 0, 32'h0,        0);
    xfer(32'h0000_0103, 1'b0, 2'b10, 32'h1122_3344,  0, 0, 32'h0,        0);
    xfer(32'h0000_0201, 1'b0, 2'b11, 32'h5566_7788,  0, 1, 32'h0,        0);
    xfer(32'h4000_0020, 1'b1, 2'b10, 32'h0,          1, 0, 32'h1111_2222, 3);
    xfer(32'h4000_0030, 1'b1, 2'b00, 32'h0,          2, 0, 32'h1234_5678, 0);
    for (int i = 0; i < 4; i++)
      xfer($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
           0, $urandom_range(0, 1), $urandom, 0);

    // reset while strobes are driven
    @(negedge clk);
    req = 1'b1; req_addr = 32'h4000_0040; req_read = 1'b0; req_siz = 2'b00;
    req_wdata = 32'hA5A5_5A5A; bus_grant = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_ds", ds_n, 4'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rdata_model = '0;
    chk("rstd_fcs", fcs_n, 1);
    chk("rstd_ds", ds_n, 4'hf);
    chk("rstd_a_oe", a_oe, 0);
    chk("rstd_busy", busy, 0);
    chk("rstd_done", done, 0);
    chk("rstd_d_oe", d_oe, 0);
    xfer(32'h4000_0044, 1'b1, 2'b00, 32'h0, 0, 0, 32'hCAFE_F00D, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/z3_master_cycle.md
# z3_master_cycle

Zorro III bus-master cycle engine: executes one single (non-burst) Zorro III transfer per local request, driving address, FCS, READ, DOE, DS_n and write data, then completing on the target's DTACK, a bus error or a local timeout. It is the initiator counterpart of the board's Zorro slave state machine. It sits between the DMA path and the Zorro buffers/transceivers. Bus arbitration is external; this block only runs cycles while granted.

## Interface
- TIMEOUT, 200, DATA-state cycles without DTACK/BERR before self-termination (1..255)
- CLK  in  1  25 MHz board clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- REQ  in  1  transfer request; sampled only in IDLE
- REQ_ADDR  in  32  byte address
- REQ_READ  in  1  1 = read, 0 = write
- REQ_SIZ  in  2  68030 size code: 00 = 4 bytes, 01 = 1, 10 = 2, 11 = 3
- REQ_WDATA  in  32  write data, big-endian lane layout (D31:24 = offset 0)
- BUS_GRANT  in  1  external arbiter grants bus to board
- DTACK_n, BERR_n  in  1 each  raw Zorro inputs, asynchronous
- D_IN  in  32  raw data bus
- A_OUT / A_OE  out  32 / 1  address and its enable
- FCS_n_OUT, DOE_OUT, READ_OUT  out  1 each  Zorro strobes
- DS_n_OUT  out  4  DS_n[3] = D31:24 … DS_n[0] = D7:0
- D_OUT / D_OE  out  32 / 1  write data and enable
- BUSY, DONE, ERR, TMO  out  1 each  status; DONE/ERR/TMO are one-cycle pulses
- RDATA  out  32  captured read data
- XFER_CNT  out  3  bytes actually transferred (0..4)

## Operation
- Reset values: FCS_n_OUT=1, DS_n_OUT=4'b1111, DOE_OUT=0, READ_OUT=1, A_OE=0, D_OE=0, A_OUT=0, D_OUT=0, BUSY=0, DONE=0, ERR=0, TMO=0, RDATA=0, XFER_CNT=0; state IDLE.
- DTACK_n and BERR_n each pass a 2-FF synchronizer (active-high dtack_s, berr_s); decisions use stage 2 only.
- Lane mask: offset = REQ_ADDR[1:0], n = bytes from REQ_SIZ. Lanes offset..min(offset+n-1,3) enabled; offset k maps to DS_n[3-k]. Bytes past lane 3 are dropped; XFER_CNT = enabled-lane count, latched at accept.
- States:
  - IDLE: REQ && BUS_GRANT → latch request, BUSY=1, go ADDR.
  - ADDR (1 cycle): A_OE=1, A_OUT, READ_OUT driven; FCS_n high.
  - STROBE (1 cycle): FCS_n_OUT=0.
  - DATA: DOE_OUT=1, DS_n_OUT=mask; for writes D_OE=1, D_OUT=wdata. Timeout counter increments each cycle. berr_s → END with ERR. dtack_s → END; for reads RDATA ← D_IN on that edge. Counter reaching TIMEOUT → END with TMO and ERR.
  - END (1 cycle): DS_n_OUT=1111, DOE_OUT=0, D_OE=0, FCS_n_OUT=1; DONE=1, plus ERR/TMO as set.
  - RECOVER: A_OE=0, READ_OUT=1; wait for dtack_s=0 and berr_s=0, then IDLE, BUSY=0.
- Priority in DATA, same cycle: berr_s > dtack_s > timeout. Timeout-terminated cycles leave RDATA unchanged.
- BUS_GRANT is ignored after accept; the arbiter does not revoke mid-cycle.
- RESET in any state: all outputs return to reset values on that edge; no DONE pulse.

## Timing
- REQ sampled at edge 0 → A_OE high after edge 1, FCS_n low after edge 2, DS_n/DOE after edge 3.
- Raw DTACK falling before edge t → dtack_s at edge t+2 → END after that edge.
- Minimum cycle, with DTACK already low at DATA entry: IDLE→IDLE = 6 clocks (ADDR, STROBE, DATA×2, END, RECOVER).
- Earliest back-to-back accept: the first IDLE cycle after RECOVER exits.
- Timeout with TIMEOUT=T: END follows the T-th DATA cycle.

## Test plan
- Longword read at 0x40000010, target DTACK 3 cycles after DS_n low, D=0xDEADBEEF → DS_n=0000, RDATA=0xDEADBEEF, DONE pulse, ERR=0, XFER_CNT=4.
- Byte write at offset 2, REQ_WDATA=0x0000AB00 → DS_n=1101, D_OE=1, READ_OUT=0, DONE, XFER_CNT=1.
- Word write at offset 3 (crosses lane 3) → DS_n=1110, XFER_CNT=1; 3-byte at offset 1 → DS_n=1000, XFER_CNT=3.
- BERR and DTACK asserted in the same clock → END with DONE=1, ERR=1, TMO=0; RECOVER holds until both are released.
- No response with TIMEOUT=5 → END after 5 DATA cycles, ERR=1, TMO=1, RDATA unchanged.
- RESET asserted during DATA → next edge FCS_n=1, DS_n=1111, A_OE=0, BUSY=0, no DONE; a new REQ completes normally.
